// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: op codes for both tables and FSM states.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    // Base table (custom_en = 0)
    localparam op_t OP_ADD     = 3'b000;
    localparam op_t OP_SUB     = 3'b001;
    localparam op_t OP_AND     = 3'b010;
    localparam op_t OP_OR      = 3'b011;
    localparam op_t OP_EQ      = 3'b100;
    localparam op_t OP_NE      = 3'b101;

    // Custom table (custom_en = 1)
    localparam op_t OP_ACC_CLR = 3'b100;
    localparam op_t OP_MAC     = 3'b101;
    localparam op_t OP_MUL     = 3'b110;
    localparam op_t OP_RELU    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// done_c/product_c are valid in the cycle whose edge retires the final step.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_c,
    output logic [WIDTH-1:0] product_c
);

    localparam int unsigned STEPS = WIDTH / MUL_BITS;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    logic [2*WIDTH-1:0] pp_q;
    logic [2*WIDTH-1:0] pp_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;

    // Partial product after retiring the current low multiplier bits
    always_comb begin
        pp_d = pp_q;
        for (int i = 0; i < int'(MUL_BITS); i++) begin
            if (mplier_q[i]) begin
                pp_d = pp_d + (mcand_q << i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pp_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            pp_q     <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= CNT_W'(STEPS);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            pp_q     <= pp_d;
            mcand_q  <= mcand_q << MUL_BITS;
            mplier_q <= mplier_q >> MUL_BITS;
            cnt_q    <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_c    = busy_q && (cnt_q == CNT_W'(1));
    assign product_c = pp_d[WIDTH-1:0];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, iterative multiply and an accumulator for MAC.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             custom_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal,
    output logic [WIDTH-1:0] acc
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             illegal_q, illegal_d;
    logic             out_valid_q, out_valid_d;
    logic             is_mac_q, is_mac_d;

    logic             accept_c;
    logic             iter_op_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_ill_c;
    logic             mul_start_c;
    logic             mul_busy;
    logic             mul_done_c;
    logic [WIDTH-1:0] mul_prod_c;

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept_c  = in_valid & in_ready;
    assign iter_op_c = custom_en & ((op == OP_MUL) | (op == OP_MAC));

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start_c),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (mul_busy),
        .done_c    (mul_done_c),
        .product_c (mul_prod_c)
    );

    // Single-cycle datapath for both op tables
    always_comb begin
        alu_res_c = '0;
        alu_ill_c = 1'b0;
        if (!custom_en) begin
            case (op)
                OP_ADD:  alu_res_c = a + b;
                OP_SUB:  alu_res_c = a - b;
                OP_AND:  alu_res_c = a & b;
                OP_OR:   alu_res_c = a | b;
                OP_EQ:   alu_res_c = WIDTH'(a == b);
                OP_NE:   alu_res_c = WIDTH'(a != b);
                default: alu_ill_c = 1'b1;
            endcase
        end else begin
            case (op)
                OP_RELU:    alu_res_c = a[WIDTH-1] ? '0 : a;
                OP_ACC_CLR: alu_res_c = '0;
                OP_MUL:     alu_res_c = '0;
                OP_MAC:     alu_res_c = '0;
                default:    alu_ill_c = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = iter_op_c ? ST_MUL : ST_DONE;
            end
            ST_MUL: begin
                if (mul_done_c)     state_d = ST_DONE;
                else if (!mul_busy) state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (accept_c)       state_d = iter_op_c ? ST_MUL : ST_DONE;
                else if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; a fresh accept in DONE overrides the handshake clear
    always_comb begin
        result_d    = result_q;
        illegal_d   = illegal_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        is_mac_d    = is_mac_q;
        mul_start_c = 1'b0;

        if ((state_q == ST_DONE) && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept_c) begin
            if (iter_op_c) begin
                mul_start_c = 1'b1;
                is_mac_d    = (op == OP_MAC);
                out_valid_d = 1'b0;
            end else begin
                result_d    = alu_res_c;
                illegal_d   = alu_ill_c;
                out_valid_d = 1'b1;
                if (custom_en && (op == OP_ACC_CLR)) begin
                    acc_d = '0;
                end
            end
        end

        if ((state_q == ST_MUL) && mul_done_c) begin
            result_d    = is_mac_q ? (acc_q + mul_prod_c) : mul_prod_c;
            illegal_d   = 1'b0;
            out_valid_d = 1'b1;
            if (is_mac_q) begin
                acc_d = acc_q + mul_prod_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            illegal_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            is_mac_q    <= 1'b0;
        end else begin
            result_q    <= result_d;
            illegal_q   <= illegal_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            is_mac_q    <= is_mac_d;
        end
    end

    assign result    = result_q;
    assign illegal   = illegal_q;
    assign acc       = acc_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized ops against a behavioural model.
module tb_alu_mc;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, custom_en, illegal;
    logic [31:0] a, b, result, acc;
    logic [2:0]  op;

    logic        in_valid4, in_ready4, out_valid4, illegal4;
    logic [31:0] a4, b4, result4, acc4;
    logic [2:0]  op4;

    int          n_checks;
    int          n_errors;
    logic [31:0] model_acc;

    alu_mc #(.WIDTH(32), .MUL_BITS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .custom_en(custom_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal), .acc(acc)
    );

    alu_mc #(.WIDTH(32), .MUL_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .op(op4), .custom_en(1'b1),
        .out_valid(out_valid4), .out_ready(1'b1),
        .result(result4), .illegal(illegal4), .acc(acc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: plain arithmetic from the op tables, latency for MUL_BITS=1
    function automatic void ref_op(input bit cen, input logic [2:0] o,
                                   input logic [31:0] av, input logic [31:0] bv,
                                   input logic [31:0] acc_in,
                                   output logic [31:0] res, output logic ill,
                                   output logic [31:0] acc_out, output int lat);
        res = 0; ill = 0; acc_out = acc_in; lat = 1;
        if (!cen) begin
            case (o)
                3'd0: res = av + bv;
                3'd1: res = av - bv;
                3'd2: res = av & bv;
                3'd3: res = av | bv;
                3'd4: res = (av == bv) ? 32'd1 : 32'd0;
                3'd5: res = (av != bv) ? 32'd1 : 32'd0;
                default: ill = 1;
            endcase
        end else begin
            case (o)
                3'd6: begin res = av * bv; lat = 33; end
                3'd7: res = ($signed(av) < 0) ? 32'd0 : av;
                3'd5: begin res = acc_in + av * bv; acc_out = res; lat = 33; end
                3'd4: acc_out = 0;
                default: ill = 1;
            endcase
        end
    endfunction

    // One request with out_ready held 1; checks latency, result, illegal, acc
    task automatic run_op(input bit cen, input logic [2:0] o,
                          input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] er, ea;
        logic        ei;
        int          el, lat, w;
        ref_op(cen, o, av, bv, model_acc, er, ei, ea, el);
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        custom_en = cen; op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom); custom_en = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        model_acc = ea;
        chk("latency", 32'(lat), 32'(el));
        chk("result", result, er);
        chk("illegal", 32'(illegal), 32'(ei));
        chk("acc", acc, model_acc);
    endtask

    initial begin
        logic [2:0]  bb_op [3];
        logic [31:0] bb_a [3], bb_b [3], bb_exp [3];
        int          lat, pulses;

        n_checks = 0; n_errors = 0; model_acc = 0;
        rst = 1'b1; in_valid = 0; out_ready = 1; custom_en = 0; op = 0; a = 0; b = 0;
        in_valid4 = 0; a4 = 0; b4 = 0; op4 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_acc", acc, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Base ops back-to-back, one result per cycle
        bb_op = '{3'd0, 3'd1, 3'd4};
        bb_a  = '{32'hFFFF_FFFF, 32'd3, 32'd7};
        bb_b  = '{32'd1, 32'd5, 32'd7};
        bb_exp = '{32'd0, 32'hFFFF_FFFE, 32'd1};
        out_ready = 1; custom_en = 0;
        for (int i = 0; i < 3; i++) begin
            op = bb_op[i]; a = bb_a[i]; b = bb_b[i]; in_valid = 1;
            @(posedge clk);
            @(negedge clk);
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_result", result, bb_exp[i]);
        end
        in_valid = 0;
        @(negedge clk);
        chk("b2b_drained", 32'(out_valid), 32'd0);

        // Multiply
        run_op(1, 3'd6, 32'h0001_0000, 32'h0001_0000);
        run_op(1, 3'd6, 32'd12, 32'd13);

        // MUL_BITS=4 instance latency
        @(negedge clk);
        op4 = 3'd6; a4 = 12; b4 = 13; in_valid4 = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 0; a4 = 32'hDEAD; b4 = 32'hBEEF;
        lat = 1;
        while (!out_valid4 && lat < 100) begin @(negedge clk); lat++; end
        chk("mul4_latency", 32'(lat), 32'd9);
        chk("mul4_result", result4, 32'd156);

        // MAC / ACC_CLR
        run_op(1, 3'd4, 32'd9, 32'd9);
        run_op(1, 3'd5, 32'd2, 32'd3);
        chk("mac1_acc", acc, 32'd6);
        run_op(1, 3'd5, 32'd4, 32'd5);
        chk("mac2_acc", acc, 32'd26);
        run_op(1, 3'd4, 32'd0, 32'd0);
        chk("clr_acc", acc, 32'd0);

        // ReLU and illegal (with nonzero acc to confirm it is untouched)
        run_op(1, 3'd7, 32'h8000_0001, 32'd0);
        run_op(1, 3'd7, 32'd5, 32'd0);
        run_op(1, 3'd5, 32'd3, 32'd3);
        run_op(1, 3'd0, 32'd11, 32'd22);
        chk("illegal_acc_kept", acc, 32'd9);
        run_op(0, 3'd6, 32'd1, 32'd1);

        // Backpressure: hold DONE 5 cycles with operand churn
        @(negedge clk);
        custom_en = 0; op = 3'd0; a = 10; b = 20; in_valid = 1; out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        a = $urandom; b = $urandom; op = 3'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", result, 32'd30);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("bp_release", 32'(out_valid), 32'd0);

        // Reset mid-MUL aborts the op and clears acc
        run_op(1, 3'd5, 32'd7, 32'd7);
        @(negedge clk);
        custom_en = 1; op = 3'd6; a = 32'd100; b = 32'd100; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        repeat (5) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        model_acc = 0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_acc", acc, 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            if ($urandom_range(0, 4) == 0) rb = ra;
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
